// File: rtl/ysyx_23060240_pkg.sv
// Shared constants and types for the ysyx_23060240 core (IFU and datapath).
package ysyx_23060240_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Fetch FSM: issue request, wait for response, hold word until consumed.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } ifu_state_e;

    // A fetch address is usable only when it is word aligned.
    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/ysyx_23060240_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues one imem read per
// instruction and holds the returned word until downstream consumes it.
module ysyx_23060240_ifu
    import ysyx_23060240_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] dnpc,
    output logic            fetch_fault
);

    ifu_state_e      state_r;
    ifu_state_e      state_next_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] inst_r;
    logic            inst_valid_r;
    logic            fetch_fault_r;
    logic            pc_aligned_s;

    assign pc_aligned_s = is_word_aligned(pc_r[1:0]);

    // State register plus the fetch PC and instruction holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= REQ;
            pc_r          <= RESET_PC;
            inst_r        <= NOP_INST;
            inst_valid_r  <= 1'b0;
            fetch_fault_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                REQ: begin
                    // A misaligned pc is never sent to memory; it is reported
                    // downstream as a faulting NOP so execute can redirect.
                    if (!pc_aligned_s) begin
                        inst_r        <= NOP_INST;
                        inst_valid_r  <= 1'b1;
                        fetch_fault_r <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        inst_r        <= imem_resp_err ? NOP_INST : imem_resp_data;
                        inst_valid_r  <= 1'b1;
                        fetch_fault_r <= imem_resp_err;
                    end
                end
                HOLD: begin
                    // dnpc is taken as-is; alignment is checked on the next fetch.
                    if (inst_ready) begin
                        pc_r          <= dnpc;
                        inst_r        <= NOP_INST;
                        inst_valid_r  <= 1'b0;
                        fetch_fault_r <= 1'b0;
                    end
                end
                default: begin
                    inst_r        <= NOP_INST;
                    inst_valid_r  <= 1'b0;
                    fetch_fault_r <= 1'b0;
                end
            endcase
        end
    end

    // Next-state decode of the fetch handshake.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            REQ: begin
                if (!pc_aligned_s) begin
                    state_next_s = HOLD;
                end else if (imem_req_ready) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = REQ;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = WAIT;
                end
            end
            HOLD: begin
                if (inst_ready) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = REQ;
            end
        endcase
    end

    // Request decode: valid only in REQ with an aligned pc, address is the pc.
    always_comb begin
        imem_req_valid = 1'b0;
        imem_req_addr  = pc_r;
        case (state_r)
            REQ: begin
                if (pc_aligned_s) begin
                    imem_req_valid = 1'b1;
                end else begin
                    imem_req_valid = 1'b0;
                end
            end
            default: begin
                imem_req_valid = 1'b0;
            end
        endcase
    end

    assign inst        = inst_r;
    assign pc          = pc_r;
    assign inst_valid  = inst_valid_r;
    assign fetch_fault = fetch_fault_r;

endmodule

// File: tb/tb_ysyx_23060240_ifu.sv
// Directed, table-driven bench for the instruction fetch unit.
module tb_ysyx_23060240_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] dnpc;
    logic        fetch_fault;

    int nvec;
    int nfail;
    int accepts;
    int strays;
    logic outstanding;

    ysyx_23060240_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .pc              (pc),
        .dnpc            (dnpc),
        .fetch_fault     (fetch_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bench-side imem model: counts accepted requests and responses that
    // arrive with no request outstanding (protocol violations).
    always @(posedge clk) begin
        if (rst) begin
            outstanding <= 1'b0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                accepts     <= accepts + 1;
                outstanding <= 1'b1;
            end else if (imem_resp_valid) begin
                if (outstanding) begin
                    outstanding <= 1'b0;
                end else begin
                    strays <= strays + 1;
                end
            end
        end
    end

    typedef struct {
        logic        rr;
        logic        rsv;
        logic [31:0] rsd;
        logic        rse;
        logic        ir;
        logic [31:0] dn;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_ff;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic rr, input logic rsv, input logic [31:0] rsd,
                                input logic rse, input logic ir, input logic [31:0] dn,
                                input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
                                input logic [31:0] e_inst, input logic [31:0] e_pc,
                                input logic e_ff);
        vec_t v;
        v.rr = rr; v.rsv = rsv; v.rsd = rsd; v.rse = rse; v.ir = ir; v.dn = dn;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst;
        v.e_pc = e_pc; v.e_ff = e_ff;
        return v;
    endfunction

    task automatic drive(input logic rr, input logic rsv, input logic [31:0] rsd,
                         input logic rse, input logic ir, input logic [31:0] dn);
        imem_req_ready  = rr;
        imem_resp_valid = rsv;
        imem_resp_data  = rsd;
        imem_resp_err   = rse;
        inst_ready      = ir;
        dnpc            = dn;
    endtask

    task automatic chk(input string name, input logic e_rv, input logic [31:0] e_addr,
                       input logic e_iv, input logic [31:0] e_inst, input logic [31:0] e_pc,
                       input logic e_ff);
        nvec = nvec + 1;
        if (imem_req_valid !== e_rv || imem_req_addr !== e_addr || inst_valid !== e_iv ||
            inst !== e_inst || pc !== e_pc || fetch_fault !== e_ff) begin
            nfail = nfail + 1;
            $display("FAIL %s: got rv=%b addr=%h iv=%b inst=%h pc=%h ff=%b, want rv=%b addr=%h iv=%b inst=%h pc=%h ff=%b",
                     name, imem_req_valid, imem_req_addr, inst_valid, inst, pc, fetch_fault,
                     e_rv, e_addr, e_iv, e_inst, e_pc, e_ff);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        nvec = nvec + 1;
        if (act != exp) begin
            nfail = nfail + 1;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Hold rst over one rising edge, check the reset state, then release.
    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        chk("reset", 1'b1, RST_PC, 1'b0, NOP, RST_PC, 1'b0);
        rst = 1'b0;
    endtask

    // One cycle: drive inputs for the coming edge, check current outputs.
    task automatic cyc(input string name, input logic rr, input logic rsv, input logic [31:0] rsd,
                       input logic rse, input logic ir, input logic [31:0] dn,
                       input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
                       input logic [31:0] e_inst, input logic [31:0] e_pc, input logic e_ff);
        drive(rr, rsv, rsd, rse, ir, dn);
        #1;
        chk(name, e_rv, e_addr, e_iv, e_inst, e_pc, e_ff);
        @(negedge clk);
    endtask

    initial begin
        int a0;
        nvec = 0; nfail = 0; accepts = 0; strays = 0; outstanding = 1'b0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        //          rr    rsv   rsd           rse   ir    dnpc           e_rv  e_addr         e_iv  e_inst         e_pc           e_ff
        tbl[0]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0000, 1'b0, NOP,           32'h8000_0000, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 32'h0000_0093,1'b0, 1'b0, 32'h0,         1'b0, 32'h8000_0000, 1'b0, NOP,           32'h8000_0000, 1'b0);
        tbl[2]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_0004, 1'b0, 32'h8000_0000, 1'b1, 32'h0000_0093, 32'h8000_0000, 1'b0);
        tbl[3]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0004, 1'b0, NOP,           32'h8000_0004, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 32'h0000_0113,1'b0, 1'b0, 32'h0,         1'b0, 32'h8000_0004, 1'b0, NOP,           32'h8000_0004, 1'b0);
        tbl[5]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_0102, 1'b0, 32'h8000_0004, 1'b1, 32'h0000_0113, 32'h8000_0004, 1'b0);
        tbl[6]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,         1'b0, 32'h8000_0102, 1'b0, NOP,           32'h8000_0102, 1'b0);
        tbl[7]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_0008, 1'b0, 32'h8000_0102, 1'b1, NOP,           32'h8000_0102, 1'b1);
        tbl[8]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0008, 1'b0, NOP,           32'h8000_0008, 1'b0);
        tbl[9]  = mk(1'b0, 1'b1, 32'hDEAD_BEEF,1'b1, 1'b0, 32'h0,         1'b0, 32'h8000_0008, 1'b0, NOP,           32'h8000_0008, 1'b0);
        tbl[10] = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_0010, 1'b0, 32'h8000_0008, 1'b1, NOP,           32'h8000_0008, 1'b1);
        tbl[11] = mk(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,         1'b1, 32'h8000_0010, 1'b0, NOP,           32'h8000_0010, 1'b0);
        tbl[12] = mk(1'b0, 1'b1, 32'h0010_0093,1'b0, 1'b0, 32'h0,         1'b0, 32'h8000_0010, 1'b0, NOP,           32'h8000_0010, 1'b0);
        tbl[13] = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h1234_5678, 1'b0, 32'h8000_0010, 1'b1, 32'h0010_0093, 32'h8000_0010, 1'b0);
        tbl[14] = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h8000_0010, 1'b1, 32'h0010_0093, 32'h8000_0010, 1'b0);
        tbl[15] = mk(1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, NOP,           32'hFFFF_FFFC, 1'b0);
        tbl[16] = mk(1'b0, 1'b1, 32'h0020_0093,1'b0, 1'b0, 32'h0,         1'b0, 32'hFFFF_FFFC, 1'b0, NOP,           32'hFFFF_FFFC, 1'b0);
        tbl[17] = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0020_0093, 32'hFFFF_FFFC, 1'b0);
        tbl[18] = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, NOP,           32'h0000_0000, 1'b0);

        // Table: normal fetch, misaligned dnpc, imem error, hold, pc wrap.
        do_reset();
        for (int i = 0; i < 19; i++) begin
            cyc($sformatf("vec%0d", i), tbl[i].rr, tbl[i].rsv, tbl[i].rsd, tbl[i].rse, tbl[i].ir,
                tbl[i].dn, tbl[i].e_rv, tbl[i].e_addr, tbl[i].e_iv, tbl[i].e_inst, tbl[i].e_pc,
                tbl[i].e_ff);
        end

        // req_ready low for 5 cycles: request must stay up with a stable address.
        do_reset();
        a0 = accepts;
        for (int i = 0; i < 5; i++) begin
            cyc("stall_req", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
                1'b1, RST_PC, 1'b0, NOP, RST_PC, 1'b0);
        end
        cyc("accept", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, RST_PC, 1'b0, NOP, RST_PC, 1'b0);
        cyc("wait1", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, RST_PC, 1'b0, NOP, RST_PC, 1'b0);
        chk_int("one_accept", accepts - a0, 1);

        // L=4 response, then downstream stalls for 3 cycles.
        do_reset();
        a0 = accepts;
        cyc("l4_req", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, RST_PC, 1'b0, NOP, RST_PC, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc("l4_wait", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, RST_PC, 1'b0, NOP, RST_PC, 1'b0);
        end
        cyc("l4_resp", 1'b1, 1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0,
            1'b0, RST_PC, 1'b0, NOP, RST_PC, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc("l4_hold", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8000_0F00,
                1'b0, RST_PC, 1'b1, 32'h0050_0093, RST_PC, 1'b0);
        end
        chk_int("l4_no_second_req", accepts - a0, 1);
        cyc("l4_consume", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0040,
            1'b0, RST_PC, 1'b1, 32'h0050_0093, RST_PC, 1'b0);
        cyc("l4_next", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
            1'b1, 32'h8000_0040, 1'b0, NOP, 32'h8000_0040, 1'b0);

        // Reset in WAIT (with a coincident response), then a stray response in REQ.
        do_reset();
        a0 = strays;
        cyc("rw_req", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, RST_PC, 1'b0, NOP, RST_PC, 1'b0);
        rst = 1'b1;
        cyc("rw_wait", 1'b0, 1'b1, 32'h0070_0093, 1'b0, 1'b0, 32'h0,
            1'b0, RST_PC, 1'b0, NOP, RST_PC, 1'b0);
        rst = 1'b0;
        cyc("rw_after", 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,
            1'b1, RST_PC, 1'b0, NOP, RST_PC, 1'b0);
        cyc("rw_stray_ign", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
            1'b1, RST_PC, 1'b0, NOP, RST_PC, 1'b0);
        chk_int("stray_seen", strays - a0, 1);

        // Reset in HOLD with a coincident consume: reset wins.
        cyc("rh_wait", 1'b0, 1'b1, 32'h0080_0093, 1'b0, 1'b0, 32'h0,
            1'b0, RST_PC, 1'b0, NOP, RST_PC, 1'b0);
        rst = 1'b1;
        cyc("rh_hold", 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_1000,
            1'b0, RST_PC, 1'b1, 32'h0080_0093, RST_PC, 1'b0);
        rst = 1'b0;
        cyc("rh_after", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
            1'b1, RST_PC, 1'b0, NOP, RST_PC, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
